// File: rtl/ft_sync_pkg.sv
// Shared types and parameter checks for the FTDI synchronous-FIFO PHY.
package ft_sync_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_OE,
        RD,
        WR,
        TURN
    } ft_state_e;

    typedef enum logic {
        DIR_RD = 1'b0,
        DIR_WR = 1'b1
    } ft_dir_e;

    localparam int unsigned FT_MIN_BURST = 2;

    function automatic bit ft_width_ok(input int unsigned w);
        return (w == 8) || (w == 16) || (w == 32);
    endfunction

endpackage

// File: rtl/ft_sync_siwu_timer.sv
// Post-burst idle counter; pulses the active-low SIWU line once per write burst.
module ft_sync_siwu_timer
    import ft_sync_pkg::*;
#(
    parameter int unsigned SIWU_IDLE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_burst_end,
    input  logic i_pop,
    input  logic i_pending,
    output logic o_siwu_n
);

    localparam int unsigned CW = $clog2(SIWU_IDLE + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SIWU_IDLE - 1);

    logic          r_armed;
    logic [CW-1:0] r_cnt;
    logic          r_siwu_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_armed  <= 1'b0;
            r_cnt    <= '0;
            r_siwu_n <= 1'b1;
        end else begin
            r_siwu_n <= 1'b1;
            if (i_pop) begin
                r_armed <= 1'b0;
            end else if (i_burst_end) begin
                r_armed <= 1'b1;
                r_cnt   <= '0;
            end else if (r_armed && !i_pending) begin
                if (r_cnt == CNT_LAST) begin
                    r_siwu_n <= 1'b0;
                    r_armed  <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign o_siwu_n = r_siwu_n;

endmodule

// File: rtl/ft_sync_fifo_phy.sv
// FT245/FT600 synchronous-FIFO PHY: arbitrated read/write bursts, write hold/replay, bus turnaround.
// Optional send-immediate flush enabled by defining FT_SYNC_SIWU_EN.
module ft_sync_fifo_phy
    import ft_sync_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BURST_MAX  = 64,
    parameter int unsigned SIWU_IDLE  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    inout  logic [DATA_WIDTH-1:0] ftdi_data,
    input  logic                  ftdi_txe_n,
    input  logic                  ftdi_rxf_n,
    output logic                  ftdi_wr_n,
    output logic                  ftdi_rd_n,
    output logic                  ftdi_oe_n,
    output logic                  ftdi_siwu,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_sof,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready
);

    generate
        if (!ft_width_ok(DATA_WIDTH) || (BURST_MAX < FT_MIN_BURST) || (SIWU_IDLE < 1)) begin : g_bad_param
            $error("ft_sync_fifo_phy: unsupported parameter set");
        end
    endgenerate

    localparam int unsigned CW = $clog2(BURST_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BURST_MAX - 1);

    ft_state_e             r_state;
    ft_state_e             w_next;
    ft_dir_e               r_last_dir;
    logic                  r_wr_n;
    logic                  r_rd_n;
    logic                  r_oe_n;
    logic                  r_drive_en;
    logic [DATA_WIDTH-1:0] r_hold;
    logic                  r_hold_valid;
    logic [CW-1:0]         r_count;
    logic                  r_sof_flag;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic                  r_rx_valid;
    logic                  r_rx_sof;

    logic          w_rd_pend;
    logic          w_wr_pend;
    logic          w_wr_acc;
    logic          w_rd_cap;
    logic          w_pop;
    logic [CW-1:0] w_count_inc;

    assign w_rd_pend   = ~ftdi_rxf_n & rx_ready;
    assign w_wr_pend   = ~ftdi_txe_n & (r_hold_valid | tx_valid);
    assign w_wr_acc    = ~r_wr_n & ~ftdi_txe_n;
    assign w_rd_cap    = ~r_rd_n & ~ftdi_rxf_n;
    assign w_count_inc = (r_count == '1) ? r_count : r_count + 1'b1;

    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rd_pend && (!w_wr_pend || (r_last_dir == DIR_WR))) begin
                    w_next = RD_OE;
                end else if (w_wr_pend) begin
                    w_next = WR;
                    w_pop  = ~r_hold_valid;
                end
            end
            RD_OE: w_next = RD;
            RD: begin
                if (ftdi_rxf_n || !rx_ready || ((r_count == CNT_LAST) && w_wr_pend))
                    w_next = TURN;
            end
            WR: begin
                // wr_n is always low here, so a non-accepted cycle means TXE_n refused the word
                if (w_wr_acc) begin
                    if (tx_valid && ((r_count < CNT_LAST) || !w_rd_pend))
                        w_pop = 1'b1;
                    else
                        w_next = TURN;
                end else begin
                    w_next = IDLE;
                end
            end
            TURN:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign tx_ready = w_pop & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_dir   <= DIR_WR;
            r_wr_n       <= 1'b1;
            r_rd_n       <= 1'b1;
            r_oe_n       <= 1'b1;
            r_drive_en   <= 1'b0;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_count      <= '0;
            r_sof_flag   <= 1'b0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_rx_sof     <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_rx_sof   <= 1'b0;
            if (w_pop) begin
                r_hold       <= tx_data;
                r_hold_valid <= 1'b1;
            end
            if (w_rd_cap) begin
                r_rx_data  <= ftdi_data;
                r_rx_valid <= 1'b1;
                r_rx_sof   <= r_sof_flag;
                r_sof_flag <= 1'b0;
                r_count    <= w_count_inc;
            end
            case (r_state)
                IDLE: begin
                    if (w_next == RD_OE) begin
                        r_oe_n     <= 1'b0;
                        r_drive_en <= 1'b0;
                        r_count    <= '0;
                        r_sof_flag <= 1'b1;
                    end else if (w_next == WR) begin
                        r_drive_en <= 1'b1;
                        r_wr_n     <= 1'b0;
                        r_count    <= '0;
                    end
                end
                RD_OE: r_rd_n <= 1'b0;
                RD: begin
                    if (w_next == TURN) begin
                        r_rd_n     <= 1'b1;
                        r_oe_n     <= 1'b1;
                        r_last_dir <= DIR_RD;
                    end
                end
                WR: begin
                    if (w_wr_acc) begin
                        r_count <= w_count_inc;
                        if (w_next == TURN) begin
                            r_hold_valid <= 1'b0;
                            r_wr_n       <= 1'b1;
                            r_drive_en   <= 1'b0;
                            r_last_dir   <= DIR_WR;
                        end
                    end else begin
                        r_wr_n <= 1'b1;
                    end
                end
                TURN:    r_drive_en <= 1'b0;
                default: ;
            endcase
        end
    end

    assign ftdi_data = r_drive_en ? r_hold : 'z;
    assign ftdi_wr_n = r_wr_n;
    assign ftdi_rd_n = r_rd_n;
    assign ftdi_oe_n = r_oe_n;
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign rx_sof    = r_rx_sof;

`ifdef FT_SYNC_SIWU_EN
    logic w_burst_end;
    assign w_burst_end = (r_state == WR) && (w_next == TURN);

    ft_sync_siwu_timer #(
        .SIWU_IDLE(SIWU_IDLE)
    ) u_siwu (
        .clk        (clk),
        .rst        (rst),
        .i_burst_end(w_burst_end),
        .i_pop      (tx_ready),
        .i_pending  (tx_valid | r_hold_valid),
        .o_siwu_n   (ftdi_siwu)
    );
`else
    assign ftdi_siwu = 1'b1;
`endif

endmodule

// File: tb/tb_ft_sync_fifo_phy.sv
// Scoreboard bench for ft_sync_fifo_phy with an FTDI chip model; BURST_MAX = 4, SIWU_IDLE = 16.
module tb_ft_sync_fifo_phy;

    localparam int unsigned DW = 8;
    localparam int unsigned BM = 4;
    localparam int unsigned SI = 16;

    logic          clk = 1'b0;
    logic          rst;
    wire  [DW-1:0] ftdi_data;
    logic          ftdi_txe_n;
    logic          ftdi_rxf_n;
    logic          ftdi_wr_n;
    logic          ftdi_rd_n;
    logic          ftdi_oe_n;
    logic          ftdi_siwu;
    logic [DW-1:0] rx_data;
    logic          rx_sof;
    logic          rx_valid;
    logic          rx_ready;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] rd_mem [64];
    int unsigned   rd_len = 0;
    int unsigned   rd_idx = 0;
    logic [DW-1:0] tx_mem [64];
    int unsigned   tx_len = 0;
    int unsigned   tx_idx = 0;
    logic          tx_en  = 1'b0;

    typedef struct {
        logic [DW-1:0] data;
        logic          sof;
    } rx_exp_t;

    rx_exp_t       rx_q [$];
    logic [DW-1:0] wr_q [$];
    rx_exp_t       mon_rx;
    logic [DW-1:0] mon_wr;

    ft_sync_fifo_phy #(
        .DATA_WIDTH(DW),
        .BURST_MAX (BM),
        .SIWU_IDLE (SI)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ftdi_data (ftdi_data),
        .ftdi_txe_n(ftdi_txe_n),
        .ftdi_rxf_n(ftdi_rxf_n),
        .ftdi_wr_n (ftdi_wr_n),
        .ftdi_rd_n (ftdi_rd_n),
        .ftdi_oe_n (ftdi_oe_n),
        .ftdi_siwu (ftdi_siwu),
        .rx_data   (rx_data),
        .rx_sof    (rx_sof),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
    );

    always #5 clk = ~clk;

    // Chip model: presents the next read word while OE_n is low; pops on each RD_n strobe.
    assign ftdi_rxf_n = !(rd_idx < rd_len);
    assign ftdi_data  = ftdi_oe_n ? 'z : ((rd_idx < rd_len) ? rd_mem[rd_idx[5:0]] : '0);
    assign tx_valid   = tx_en && (tx_idx < tx_len);
    assign tx_data    = (tx_idx < tx_len) ? tx_mem[tx_idx[5:0]] : '0;

    always @(posedge clk) begin
        if (!ftdi_rd_n && !ftdi_rxf_n) rd_idx <= rd_idx + 1;
        if (tx_ready) tx_idx <= tx_idx + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected rx words and chip-accepted write words
    always @(negedge clk) begin
        if (rx_valid) begin
            if (rx_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rx_unexpected: got word 0x%0h, expected no word (t=%0t)", rx_data, $time);
            end else begin
                mon_rx = rx_q.pop_front();
                check("rx_data", 32'(rx_data), 32'(mon_rx.data));
                check("rx_sof", 32'(rx_sof), 32'(mon_rx.sof));
            end
        end
        if (!rst && !ftdi_wr_n && !ftdi_txe_n) begin
            if (wr_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL wr_unexpected: chip got 0x%0h, expected no word (t=%0t)", ftdi_data, $time);
            end else begin
                mon_wr = wr_q.pop_front();
                check("chip_wr_data", 32'(ftdi_data), 32'(mon_wr));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && (rx_q.size() != 0 || wr_q.size() != 0); i++) tick();
        check("drain_rx", rx_q.size(), 0);
        check("drain_wr", wr_q.size(), 0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned p;
        rst        = 1'b1;
        ftdi_txe_n = 1'b1;
        rx_ready   = 1'b1;
        repeat (2) tick();

        // Reset values
        check("rst_wr_n", ftdi_wr_n, 1);
        check("rst_rd_n", ftdi_rd_n, 1);
        check("rst_oe_n", ftdi_oe_n, 1);
        check("rst_siwu", ftdi_siwu, 1);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_sof", rx_sof, 0);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_bus_hiz", 32'(ftdi_data === 8'hzz), 1);
        rst = 1'b0;
        repeat (2) tick();

        // Read burst of 5 words
        for (int i = 0; i < 5; i++) begin
            rd_mem[i] = 8'h11 + 8'(i);
            rx_q.push_back('{data: 8'h11 + 8'(i), sof: (i == 0)});
        end
        rd_len = 5;
        tick();
        check("rd_oe_first", ftdi_oe_n, 0);
        check("rd_rd_after_oe", ftdi_rd_n, 1);
        tick();
        check("rd_rd_low", ftdi_rd_n, 0);
        check("rd_oe_held", ftdi_oe_n, 0);
        tick();
        check("rd_first_valid", rx_valid, 1);
        wait_drain(20);
        repeat (4) tick();

        // Backpressure after word 3 of 10
        for (int i = 0; i < 10; i++) rd_mem[5 + i] = 8'h20 + 8'(i);
        for (int i = 0; i < 4; i++) rx_q.push_back('{data: 8'h20 + 8'(i), sof: (i == 0)});
        rd_len = 15;
        repeat (5) tick();
        rx_ready = 1'b0;
        tick();
        check("bp_rd_n_high", ftdi_rd_n, 1);
        check("bp_oe_n_high", ftdi_oe_n, 1);
        repeat (3) tick();
        check("bp_stalled", rx_q.size(), 0);
        for (int i = 4; i < 10; i++) rx_q.push_back('{data: 8'h20 + 8'(i), sof: (i == 4)});
        rx_ready = 1'b1;
        wait_drain(30);
        repeat (4) tick();

        // Write A, B, C with TXE_n raised while B is driven
        tx_mem[0] = 8'hA1;
        tx_mem[1] = 8'hB2;
        tx_mem[2] = 8'hC3;
        wr_q.push_back(8'hA1);
        wr_q.push_back(8'hB2);
        wr_q.push_back(8'hC3);
        tx_len     = 3;
        tx_en      = 1'b1;
        ftdi_txe_n = 1'b0;
        tick();
        check("wr_a_strobe", ftdi_wr_n, 0);
        check("wr_a_bus", 32'(ftdi_data), 32'h A1);
        tick();
        check("wr_b_bus", 32'(ftdi_data), 32'hB2);
        ftdi_txe_n = 1'b1;
        tick();
        check("wr_refused_strobe", ftdi_wr_n, 1);
        ftdi_txe_n = 1'b0;
        check("wr_replay_no_pop", tx_ready, 0);
        tick();
        check("wr_b_resent_strobe", ftdi_wr_n, 0);
        check("wr_b_resent_bus", 32'(ftdi_data), 32'hB2);
        tick();
        check("wr_c_bus", 32'(ftdi_data), 32'hC3);
        tick();
        check("wr_end_strobe", ftdi_wr_n, 1);
        check("wr_pops", tx_idx, 3);
        check("wr_drain", wr_q.size(), 0);

        // SIWU after the last acceptance
        for (int k = 1; k <= 18; k++) begin
            tick();
`ifdef FT_SYNC_SIWU_EN
            check("siwu_pulse", ftdi_siwu, (k == 16) ? 0 : 1);
`else
            check("siwu_idle_high", ftdi_siwu, 1);
`endif
        end

        // Arbitration: both directions pending, bursts of 4
        for (int i = 0; i < 8; i++) begin
            rd_mem[15 + i] = 8'h40 + 8'(i);
            rx_q.push_back('{data: 8'h40 + 8'(i), sof: (i == 0 || i == 4)});
            tx_mem[3 + i] = 8'h80 + 8'(i);
            wr_q.push_back(8'h80 + 8'(i));
        end
        rd_len = 23;
        tx_len = 11;
        for (int k = 1; k <= 26; k++) begin
            tick();
            p = (k - 1) % 13;
            check("arb_oe_n", ftdi_oe_n, (p <= 4) ? 0 : 1);
            check("arb_rd_n", ftdi_rd_n, (p >= 1 && p <= 4) ? 0 : 1);
            check("arb_wr_n", ftdi_wr_n, (p >= 7 && p <= 10) ? 0 : 1);
            if (p == 5 || p == 6 || p == 11 || p == 12)
                check("arb_bus_hiz", 32'(ftdi_data === 8'hzz), 1);
        end
        wait_drain(10);
        repeat (4) tick();

        // Reset mid-write: held word D1 is lost
        tx_mem[11] = 8'hD0;
        tx_mem[12] = 8'hD1;
        tx_mem[13] = 8'hD2;
        wr_q.push_back(8'hD0);
        wr_q.push_back(8'hD2);
        tx_len = 14;
        repeat (2) tick();
        rst = 1'b1;
        #1;
        check("rstw_wr_n", ftdi_wr_n, 1);
        check("rstw_rd_n", ftdi_rd_n, 1);
        check("rstw_oe_n", ftdi_oe_n, 1);
        check("rstw_bus_hiz", 32'(ftdi_data === 8'hzz), 1);
        check("rstw_tx_ready", tx_ready, 0);
        repeat (2) tick();
        ftdi_txe_n = 1'b1;
        rst        = 1'b0;
        tick();
        check("post_rst_wr_n", ftdi_wr_n, 1);
        check("post_rst_tx_ready", tx_ready, 0);
        check("post_rst_bus_hiz", 32'(ftdi_data === 8'hzz), 1);
        check("post_rst_siwu", ftdi_siwu, 1);
        ftdi_txe_n = 1'b0;
        wait_drain(20);
        check("post_rst_pops", tx_idx, 14);
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
